muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage, alongside the single-cycle ALU. It executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU in a fixed 34-cycle sequence and exchanges operands and results with the control path over a Start/Busy/Done handshake. The main decoder issues an operation with Start and stalls PC and register writeback until Done. MDResult is then muxed into the result path in the same way as ALUResult.

## Interface
- No parameters. Datapath width is fixed at 32 bits.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  request pulse. Sampled only in IDLE or DONE.
- MDControl  in  3  operation code (instruction funct3): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  in  32  rs1 operand: multiplicand or dividend.
- SrcB  in  32  rs2 operand: multiplier or divisor.
- Busy  out  1  high while an operation is in flight (CALC, FIX).
- Done  out  1  one-cycle pulse; MDResult is valid in this cycle.
- MDResult  out  32  result register; holds its value until the next Done.

## Operation
- States: IDLE, CALC, FIX, DONE. A 5-bit iteration counter runs in CALC.
- **IDLE**
  - Start=1: latch MDControl, SrcA, SrcB. Record operand signs per the op (MULH and DIV/REM: both signed; MULHSU: SrcA signed; others unsigned). Latch operand magnitudes. Clear the accumulator and counter. Go to CALC.
  - Start=0: stay in IDLE.
- **CALC**, 32 cycles, one bit per cycle:
  - Multiply: shift-add on magnitudes into a 64-bit product register.
  - Divide: restoring shift-subtract on magnitudes, giving quotient and remainder.
  - Leave for FIX when counter = 31.
- **FIX**, 1 cycle: apply signs and special cases, write MDResult.
  - MUL: product[31:0].
  - MULH, MULHSU, MULHU: product[63:32], after 64-bit two's-complement negation if the result sign is negative.
  - DIV: quotient sign = signA XOR signB.
  - REM: remainder takes the sign of the dividend.
  - Divisor = 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return SrcA. This overrides the iterative result; latency is unchanged.
  - DIV with 0x80000000 / 0xFFFFFFFF: return 0x80000000. REM with the same operands: return 0.
- **DONE**, 1 cycle: Done=1, Busy=0.
  - Start=1: accept new operands exactly as IDLE does and go to CALC (back-to-back issue).
  - Otherwise: go to IDLE.
- Operand inputs are ignored outside the accept cycle. Changes to SrcA, SrcB or MDControl during CALC or FIX have no effect.
- Start while Busy=1 is ignored. It is not queued and has no side effect.
- Reset asserted at any time, including mid-operation:
  - State goes to IDLE; Busy=0, Done=0, MDResult=0, counter=0.
  - The operation in flight is discarded. No Done is produced for it.

## Timing
- Reset values: Busy=0, Done=0, MDResult=0x00000000, state IDLE.
- Start is high in cycle 0 (sampled at the end of cycle 0).
  - Cycles 1–32: CALC, Busy=1.
  - Cycle 33: FIX, Busy=1.
  - Cycle 34: DONE, Done=1, Busy=0, MDResult valid.
- Latency is 34 cycles for every op, including divide-by-zero and overflow. There is no early termination.
- All outputs are registered; there is no combinational path from any input to any output.
- MDResult changes only on the clock edge that enters DONE. It is stable from cycle 34 until the next DONE or reset.
- Throughput: one op per 34 cycles with back-to-back issue; Start in cycle 34 puts the next CALC in cycle 35.
- Busy and Done are never both high.

## Test plan
- After reset: Busy=0, Done=0, MDResult=0.
- MUL: 7 × 0xFFFFFFFD gives 0xFFFFFFEB in cycle 34.
  - Same inputs with MULHU gives 0x00000006.
  - Same inputs with MULH gives 0xFFFFFFFF.
- Multiply upper half:
  - MULH 0x80000000 × 0x80000000 gives 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFF.
- Signed divide:
  - DIV 0xFFFFFFF9 (−7) / 2 gives 0xFFFFFFFD.
  - REM with the same operands gives 0xFFFFFFFF.
  - DIVU with the same operands gives 0x7FFFFFFC.
- Special cases:
  - DIVU 5 / 0 gives 0xFFFFFFFF; REMU 5 / 0 gives 0x00000005.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
  - Each completes with Done in cycle 34.
- Handshake and reset:
  - Start=1 during cycle 10 with other operands: ignored, first result unchanged.
  - Start=1 in the DONE cycle: second Done arrives 34 cycles later.
  - Reset pulled low in cycle 20 of an op: Busy=0 immediately, MDResult=0, no Done afterwards.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Every operation takes 34 cycles: one accept cycle, 32 CALC cycles, one FIX
// cycle, then a one-cycle Done pulse with MDResult valid.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   Start      request pulse, sampled only in IDLE or DONE
//   MDControl  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   SrcA       rs1: multiplicand / dividend
//   SrcB       rs2: multiplier / divisor
//   Busy       high in CALC and FIX
//   Done       one-cycle pulse in DONE
//   MDResult   result register, updated only on entry to DONE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for Start
// CALC  | 32 iterations, one operand bit per cycle
// FIX   | apply signs and special cases, load MDResult
// DONE  | Done pulse; Start here issues the next op back-to-back
module muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDControl,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] MDResult
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state_q,  state_d;
   logic [4:0]  cnt_q,    cnt_d;
   logic [2:0]  op_q,     op_d;
   logic        sign_a_q, sign_a_d;
   logic        sign_b_q, sign_b_d;
   logic [31:0] a_q,      a_d;
   logic [31:0] b_q,      b_d;
   logic [63:0] acc_q,    acc_d;
   logic [31:0] result_q, result_d;

   logic        in_sign_a, in_sign_b;
   logic [32:0] rem_shift, rem_sub;
   logic [63:0] prod_adj;
   logic [31:0] quo_adj, rem_adj;

   // acc_q holds the 64-bit product for multiplies; for divides the upper
   // half is the partial remainder and the lower half collects quotient bits.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;

      // MULH, DIV, REM: both signed; MULHSU: only SrcA signed.
      in_sign_a = 1'b0;
      in_sign_b = 1'b0;
      if (MDControl == 3'b001 || MDControl == 3'b100 || MDControl == 3'b110) begin
         in_sign_a = SrcA[31];
         in_sign_b = SrcB[31];
      end else if (MDControl == 3'b010) begin
         in_sign_a = SrcA[31];
      end

      rem_shift = {acc_q[63:32], a_q[31]};
      rem_sub   = rem_shift - {1'b0, b_q};

      prod_adj = (sign_a_q ^ sign_b_q) ? (64'd0 - acc_q) : acc_q;
      quo_adj  = (sign_a_q ^ sign_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      rem_adj  = sign_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

      case (state_q)
         S_IDLE, S_DONE: begin
            if (Start) begin
               op_d     = MDControl;
               sign_a_d = in_sign_a;
               sign_b_d = in_sign_b;
               // 0x80000000 negates to itself, which is the correct magnitude.
               a_d      = in_sign_a ? (32'd0 - SrcA) : SrcA;
               b_d      = in_sign_b ? (32'd0 - SrcB) : SrcB;
               acc_d    = 64'd0;
               cnt_d    = 5'd0;
               state_d  = S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + 5'd1;
            if (op_q[2]) begin
               // Restoring divide: dividend bits enter MSB first from a_q.
               a_d = a_q << 1;
               if (!rem_sub[32])
                  acc_d = {rem_sub[31:0], acc_q[30:0], 1'b1};
               else
                  acc_d = {rem_shift[31:0], acc_q[30:0], 1'b0};
            end else begin
               // Shift-add, multiplier bits consumed MSB first.
               b_d   = b_q << 1;
               acc_d = {acc_q[62:0], 1'b0} + (b_q[31] ? {32'd0, a_q} : 64'd0);
            end
            if (cnt_q == 5'd31)
               state_d = S_FIX;
         end
         S_FIX: begin
            // With a zero divisor the restoring loop leaves |SrcA| as the
            // remainder, so REM/REMU need no override; only the quotient does.
            // Signed overflow (MIN / -1) also falls out of the sign fix-up.
            case (op_q)
               3'b000:                 result_d = acc_q[31:0];
               3'b001, 3'b010, 3'b011: result_d = prod_adj[63:32];
               3'b100, 3'b101:         result_d = (b_q == 32'd0) ? 32'hFFFF_FFFF : quo_adj;
               default:                result_d = rem_adj;
            endcase
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         op_q     <= 3'd0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         acc_q    <= 64'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign Busy     = (state_q == S_CALC) || (state_q == S_FIX);
   assign Done     = (state_q == S_DONE);
   assign MDResult = result_q;

endmodule
